// File: rtl/bmain_pkg.sv
// bmain_pkg: shared command encodings, address width and state encoding for the line master
package bmain_pkg;
  localparam logic CMD_READ = 1'b1;
  localparam logic CMD_WRITE = 1'b0;
  localparam int BMAIN_ADDR_HI = 27;
  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, RESP} state_t;
endpackage

// File: rtl/bmain_line_buf.sv
// bmain_line_buf: line register file with indexed word write and full-line parallel load/read
module bmain_line_buf #(
  parameter int LINE_WORDS = 4,
  localparam int IW = $clog2(LINE_WORDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [32*LINE_WORDS-1:0] line_i,
  input  logic                    we,
  input  logic [IW-1:0]           idx,
  input  logic [31:0]             word_i,
  output logic [32*LINE_WORDS-1:0] line_o
);
  logic [32*LINE_WORDS-1:0] line_d, line_q;
  always_comb begin
    line_d = load ? line_i : line_q;
    if (we && !load) line_d[{idx, 5'd0} +: 32] = word_i;
  end
  always_ff @(posedge clk) line_q <= rst ? '0 : line_d;
  assign line_o = line_q;
endmodule

// File: rtl/bmain_line_master.sv
// bmain_line_master: moves one cache line per request over the command/write-data/read-data bus
module bmain_line_master
  import bmain_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic                       clk_core,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [BMAIN_ADDR_HI:2]     req_addr,
  input  logic [32*LINE_WORDS-1:0]   req_wdata,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [32*LINE_WORDS-1:0]   resp_rdata,
  output logic                       resp_error,
  output logic                       bmain_cvalid,
  input  logic                       dctl_cready,
  output logic                       bmain_cmd,
  output logic [BMAIN_ADDR_HI:2]     bmain_addr,
  output logic                       bmain_wvalid,
  input  logic                       dctl_wready,
  output logic                       bmain_wlast,
  output logic [31:0]                bmain_wdata,
  output logic [3:0]                 bmain_wmask,
  input  logic                       dctl_rvalid,
  output logic                       bmain_rready,
  input  logic                       dctl_rlast,
  input  logic [31:0]                dctl_rdata,
  input  logic                       dctl_error
);
  localparam int IW = $clog2(LINE_WORDS);
  localparam logic [IW-1:0] LAST = IW'(LINE_WORDS - 1);
  localparam logic [BMAIN_ADDR_HI:2] AMASK = (BMAIN_ADDR_HI - 1)'(LINE_WORDS - 1);
  state_t state_d, state_q;
  logic [IW-1:0] cnt_d, cnt_q, cnt_inc, word_sel;
  logic err_d, err_q;
  logic req_ready_d, req_ready_q, resp_valid_d, resp_valid_q, resp_error_d, resp_error_q;
  logic cvalid_d, cvalid_q, cmd_d, cmd_q, wvalid_d, wvalid_q, wlast_d, wlast_q, rready_d, rready_q;
  logic [BMAIN_ADDR_HI:2] addr_d, addr_q;
  logic [31:0] wdata_d, wdata_q, next_word;
  logic [3:0] wmask_d, wmask_q;
  logic [32*LINE_WORDS-1:0] line;
  logic req_beat, cmd_beat, w_beat, r_beat, resp_beat, mism;
  assign req_beat  = req_valid & req_ready_q;
  assign cmd_beat  = cvalid_q & dctl_cready;
  assign w_beat    = wvalid_q & dctl_wready;
  assign r_beat    = dctl_rvalid & rready_q;
  assign resp_beat = resp_valid_q & resp_ready;
  assign mism      = r_beat & (dctl_rlast ^ (cnt_q == LAST));
  assign cnt_inc   = cnt_q + 1'b1;
  assign word_sel  = (state_q == CMD) ? '0 : cnt_inc;
  assign next_word = line[{word_sel, 5'd0} +: 32];
  bmain_line_buf #(.LINE_WORDS(LINE_WORDS)) u_buf (
    .clk(clk_core), .rst(reset), .load(req_beat), .line_i(req_wdata),
    .we(r_beat), .idx(cnt_q), .word_i(dctl_rdata), .line_o(line)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    err_d = err_q;
    req_ready_d = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_error_d = resp_error_q;
    cvalid_d = cvalid_q;
    cmd_d = cmd_q;
    addr_d = addr_q;
    wvalid_d = wvalid_q;
    wlast_d = wlast_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rready_d = rready_q;
    unique case (state_q)
      IDLE: if (req_beat) begin
        state_d = CMD;
        req_ready_d = 1'b0;
        cvalid_d = 1'b1;
        cmd_d = req_write ? CMD_WRITE : CMD_READ;
        addr_d = req_addr & ~AMASK;
        err_d = 1'b0;
      end
      CMD: begin
        err_d = err_q | dctl_error;
        if (cmd_beat) begin
          cvalid_d = 1'b0;
          cnt_d = '0;
          state_d = (cmd_q == CMD_WRITE) ? WDATA : RDATA;
          wvalid_d = cmd_q == CMD_WRITE;
          rready_d = cmd_q == CMD_READ;
          wdata_d = (cmd_q == CMD_WRITE) ? next_word : wdata_q;
          wlast_d = 1'b0;
          wmask_d = (cmd_q == CMD_WRITE) ? 4'hF : wmask_q;
        end
      end
      WDATA: begin
        err_d = err_q | dctl_error;
        if (w_beat) begin
          cnt_d = cnt_inc;
          wdata_d = next_word;
          wlast_d = !wlast_q && cnt_inc == LAST;
          wvalid_d = !wlast_q;
          state_d = wlast_q ? RESP : WDATA;
          resp_valid_d = wlast_q;
          resp_error_d = wlast_q & err_d;
        end
      end
      RDATA: begin
        err_d = err_q | dctl_error | mism;
        if (r_beat) begin
          cnt_d = cnt_inc;
          rready_d = cnt_q != LAST;
          state_d = (cnt_q == LAST) ? RESP : RDATA;
          resp_valid_d = cnt_q == LAST;
          resp_error_d = (cnt_q == LAST) & err_d;
        end
      end
      RESP: if (resp_beat) begin
        state_d = IDLE;
        resp_valid_d = 1'b0;
        resp_error_d = 1'b0;
        req_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_core) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      err_q <= 1'b0;
      req_ready_q <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      cvalid_q <= 1'b0;
      cmd_q <= 1'b0;
      addr_q <= '0;
      wvalid_q <= 1'b0;
      wlast_q <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      req_ready_q <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      cvalid_q <= cvalid_d;
      cmd_q <= cmd_d;
      addr_q <= addr_d;
      wvalid_q <= wvalid_d;
      wlast_q <= wlast_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rready_q <= rready_d;
    end
  end
  assign req_ready = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = line;
  assign bmain_cvalid = cvalid_q;
  assign bmain_cmd = cmd_q;
  assign bmain_addr = addr_q;
  assign bmain_wvalid = wvalid_q;
  assign bmain_wlast = wlast_q;
  assign bmain_wdata = wdata_q;
  assign bmain_wmask = wmask_q;
  assign bmain_rready = rready_q;
endmodule
